// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result is held until the owner accepts it.
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*OP_W-1:0]    req_op_i,
  input  logic [2*DATA_W-1:0]  req_a_i,
  input  logic [2*DATA_W-1:0]  req_b_i,
  input  logic [2*SHAMT_W-1:0] req_shamt_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_data_o,
  output logic                 rsp_zero_o,
  output logic                 rsp_err_o,
  output logic [OP_W-1:0]      alu_op_o,
  output logic [DATA_W-1:0]    alu_a_o,
  output logic [DATA_W-1:0]    alu_b_o,
  output logic [SHAMT_W-1:0]   alu_shamt_o,
  input  logic [DATA_W-1:0]    alu_data_i,
  input  logic                 alu_zero_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic                owner_q;
  logic                err_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   data_q;
  logic                zero_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [SHAMT_W-1:0]  alu_shamt_q;

  logic [1:0]          grant;
  logic                accept;
  logic                win_id;
  logic [OP_W-1:0]     op_sel;
  logic                op_is_err;
  logic                rsp_hs;

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      case (req_valid_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept    = |grant;
  assign win_id    = grant[1];
  assign op_sel    = win_id ? req_op_i[2*OP_W-1:OP_W] : req_op_i[OP_W-1:0];
  assign op_is_err = !((op_sel == OP_W'(3)) || (op_sel == OP_W'(1)) || (op_sel == OP_W'(2)));
  assign rsp_hs    = (state_q == RESP) && rsp_ready_i[owner_q];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = grant;
    rsp_valid_o = 2'b00;
    if (rsp_valid_q) rsp_valid_o = owner_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= win_id;
        owner_q      <= win_id;
        err_q        <= op_is_err;
        alu_op_q     <= op_sel;
        alu_a_q      <= win_id ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
        alu_b_q      <= win_id ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
        alu_shamt_q  <= win_id ? req_shamt_i[2*SHAMT_W-1:SHAMT_W] : req_shamt_i[SHAMT_W-1:0];
      end
      // Illegal op codes report a zero result regardless of what the ALU produced.
      if (state_q == ISSUE) begin
        data_q      <= err_q ? '0 : alu_data_i;
        zero_q      <= err_q ? 1'b1 : alu_zero_i;
        rsp_valid_q <= 1'b1;
      end
      if (rsp_hs) rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_data_o  = data_q;
  assign rsp_zero_o  = zero_q;
  assign rsp_err_o   = err_q;
  assign alu_op_o    = alu_op_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_shamt_o = alu_shamt_q;

endmodule
